fsqrt_arbiter: RTL and testbench

- Shares one fixed-latency fsqrt pipeline between two requesters (e.g. two FPU issue ports).
- Arbitrates round-robin and issues at most one operand per cycle into the pipeline.
- Tracks the source and tag of every in-flight operation in a delay line, and collects results in a result FIFO with valid/ready backpressure.
- Because the fsqrt pipeline cannot stall, credit counting guarantees the FIFO never overflows.

---
 rtl/fsqrt_arbiter.sv | 171 +++++++++++++++++
 tb/tb_fsqrt_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsqrt_arbiter.sv
// Round-robin arbiter sharing one fixed-latency fsqrt pipeline between two requesters.
// The optional performance counters are enabled with `define FSQRT_ARB_PERF_EN.
module fsqrt_arbiter #(
    parameter int unsigned LAT   = 5,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TAG_W = 4
) (
`ifdef FSQRT_ARB_PERF_EN
    output logic [31:0]      perf_issue0,
    output logic [31:0]      perf_issue1,
    output logic [31:0]      perf_stall,
`endif
    input  logic             clk,
    input  logic             rstn,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_data,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_data,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [31:0]      fsqrt_s,
    input  logic [31:0]      fsqrt_d,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic             resp_src,
    output logic [TAG_W-1:0] resp_tag
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned INF_W = $clog2(LAT + 1);
    localparam int unsigned OCC_W = $clog2(LAT + DEPTH + 1);

    typedef struct packed {
        logic             vld;
        logic             src;
        logic [TAG_W-1:0] tag;
    } dl_t;

    typedef struct packed {
        logic [31:0]      data;
        logic             src;
        logic [TAG_W-1:0] tag;
    } ent_t;

    dl_t              dl_q [LAT];
    ent_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic [INF_W-1:0] inf_q;
    logic             rr_q;   // 1: requester 1 wins a tie
    logic             run_q;  // holds grants off until the first edge after reset

    logic             credit_ok, gnt0, gnt1, issue, retire, pop, empty;
    logic [OCC_W-1:0] occ;
    dl_t              dl_in;
    ent_t             push_e, head;

    // Credit check and round-robin grant
    always_comb begin
        occ       = OCC_W'(inf_q) + OCC_W'(cnt_q);
        credit_ok = (occ < OCC_W'(DEPTH));
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        if (run_q && credit_ok) begin
            if (req0_valid && req1_valid) begin
                gnt0 = !rr_q;
                gnt1 = rr_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
        issue  = gnt0 | gnt1;
        retire = dl_q[LAT-1].vld;
        empty  = (cnt_q == '0);
        pop    = !empty && resp_ready;

        dl_in.vld = issue;
        dl_in.src = gnt1;
        dl_in.tag = gnt1 ? req1_tag : req0_tag;

        push_e.data = fsqrt_d;
        push_e.src  = dl_q[LAT-1].src;
        push_e.tag  = dl_q[LAT-1].tag;

        head = mem_q[rd_q];
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign fsqrt_s    = gnt0 ? req0_data : (gnt1 ? req1_data : 32'h0);
    assign resp_valid = !empty;
    assign resp_data  = empty ? 32'h0 : head.data;
    assign resp_src   = empty ? 1'b0 : head.src;
    assign resp_tag   = empty ? '0 : head.tag;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                dl_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            inf_q <= '0;
            rr_q  <= 1'b0;
            run_q <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            dl_q[0] <= dl_in;
            for (int unsigned i = 1; i < LAT; i++) begin
                dl_q[i] <= dl_q[i-1];
            end
            if (issue) begin
                rr_q <= gnt0;
            end
            if (issue && !retire) begin
                inf_q <= inf_q + INF_W'(1);
            end else if (!issue && retire) begin
                inf_q <= inf_q - INF_W'(1);
            end
            if (retire) begin
                wr_q <= wr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PTR_W'(1);
            end
            if (retire && !pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (!retire && pop) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // Result storage needs no reset; the head is masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (retire) begin
            mem_q[wr_q] <= push_e;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(retire && !pop && (cnt_q == CNT_W'(DEPTH))));

`ifdef FSQRT_ARB_PERF_EN
    // Saturating activity counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_issue0 <= 32'h0;
            perf_issue1 <= 32'h0;
            perf_stall  <= 32'h0;
        end else begin
            if (gnt0 && (perf_issue0 != 32'hFFFF_FFFF)) begin
                perf_issue0 <= perf_issue0 + 32'd1;
            end
            if (gnt1 && (perf_issue1 != 32'hFFFF_FFFF)) begin
                perf_issue1 <= perf_issue1 + 32'd1;
            end
            if ((req0_valid || req1_valid) && !credit_ok && (perf_stall != 32'hFFFF_FFFF)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fsqrt_arbiter.sv
// Self-checking bench for fsqrt_arbiter: fixed-latency fsqrt stand-in plus an
// outstanding-operation queue model checked on every negative clock edge.
module tb_fsqrt_arbiter;

    localparam int LAT   = 5;
    localparam int DEPTH = 8;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic             req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0]      req0_data, req1_data;
    logic [TAG_W-1:0] req0_tag, req1_tag;
    logic [31:0]      fsqrt_s, fsqrt_d;
    logic             resp_valid, resp_ready, resp_src;
    logic [31:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;
`ifdef FSQRT_ARB_PERF_EN
    logic [31:0]      perf_issue0, perf_issue1, perf_stall;
`endif

    always #5 clk = ~clk;

    fsqrt_arbiter #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
`ifdef FSQRT_ARB_PERF_EN
        .perf_issue0(perf_issue0), .perf_issue1(perf_issue1), .perf_stall(perf_stall),
`endif
        .clk(clk), .rstn(rstn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_tag(req1_tag),
        .fsqrt_s(fsqrt_s), .fsqrt_d(fsqrt_d),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_src(resp_src), .resp_tag(resp_tag)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Exact for the operands used in directed tests; a rough exponent-halving guess otherwise
    function automatic logic [31:0] fsq(input logic [31:0] x);
        case (x)
            32'h4080_0000: return 32'h4000_0000;
            32'h4110_0000: return 32'h4040_0000;
            32'h4000_0000: return 32'h3FB5_04F3;
            32'h3F80_0000: return 32'h3F80_0000;
            32'h0000_0000: return 32'h0000_0000;
            default:       return x[31] ? 32'h0 : (x >> 1) + 32'h1FC0_0000;
        endcase
    endfunction

    // External fsqrt pipeline: no reset, stale contents survive a reset
    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= fsq(fsqrt_s);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign fsqrt_d = pipe[LAT-1];

    // Reference model: every accepted op sits in q until popped; it becomes
    // visible at the head LAT+1 cycles after acceptance.
    typedef struct {
        logic [31:0]      op;
        logic             src;
        logic [TAG_W-1:0] tag;
        int               cyc;
    } exp_t;

    exp_t q[$];
    int   cyc  = 0;
    bit   prio = 1'b0;

    always @(negedge clk) begin
        bit   ok, e0, e1, vis;
        exp_t e;
        cyc++;
        if (!rstn) begin
            q.delete();
            prio = 1'b0;
            chk("rst_req0_ready", 32'(req0_ready), 32'h0);
            chk("rst_req1_ready", 32'(req1_ready), 32'h0);
            chk("rst_resp_valid", 32'(resp_valid), 32'h0);
            chk("rst_fsqrt_s", fsqrt_s, 32'h0);
            chk("rst_resp_data", resp_data, 32'h0);
        end else begin
            ok = (q.size() < DEPTH);
            e0 = ok && req0_valid && (!req1_valid || !prio);
            e1 = ok && req1_valid && (!req0_valid || prio);
            chk("m_req0_ready", 32'(req0_ready), 32'(e0));
            chk("m_req1_ready", 32'(req1_ready), 32'(e1));
            chk("m_fsqrt_s", fsqrt_s, e0 ? req0_data : (e1 ? req1_data : 32'h0));
            vis = (q.size() != 0) && (cyc >= q[0].cyc + LAT + 1);
            chk("m_resp_valid", 32'(resp_valid), 32'(vis));
            if (vis) begin
                chk("m_resp_data", resp_data, fsq(q[0].op));
                chk("m_resp_src", 32'(resp_src), 32'(q[0].src));
                chk("m_resp_tag", 32'(resp_tag), 32'(q[0].tag));
                if (resp_ready) void'(q.pop_front());
            end
            if (e0 || e1) begin
                e.op  = e0 ? req0_data : req1_data;
                e.src = e1;
                e.tag = e0 ? req0_tag : req1_tag;
                e.cyc = cyc;
                q.push_back(e);
                prio = e0;
            end
        end
    end

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (n) nxt();
    endtask

    task automatic do_reset;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rstn = 1'b0;
        repeat (2) nxt();
        rstn = 1'b1;
        repeat (2) nxt();
    endtask

    // Leaves the bench at a negedge with resp_valid high, or reports a timeout
    task automatic wait_resp(input string name, output bit got);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1'b1;
                break;
            end
            nxt();
        end
        if (!got) timeout(name);
    endtask

    initial begin
        bit got, a0, a1;
        int acc;
        logic [TAG_W-1:0] t0, t1;

        rstn = 1'b0;
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_data = 32'h4080_0000; req0_tag = '0;
        req1_valid = 1'b1; req1_data = 32'h4000_0000; req1_tag = '0;

        // Reset values, with both requesters asking
        @(negedge clk);
        chk("reset_req0_ready", 32'(req0_ready), 32'h0);
        chk("reset_req1_ready", 32'(req1_ready), 32'h0);
        chk("reset_resp_valid", 32'(resp_valid), 32'h0);
        chk("reset_fsqrt_s", fsqrt_s, 32'h0);
        chk("reset_resp_src", 32'(resp_src), 32'h0);
        chk("reset_resp_tag", 32'(resp_tag), 32'h0);
        nxt();
        do_reset();

        // Single op: sqrt(4.0) tag 3, response exactly six cycles later
        req0_valid = 1'b1; req0_data = 32'h4080_0000; req0_tag = 4'd3;
        @(negedge clk);
        chk("single_ready", 32'(req0_ready), 32'h1);
        chk("single_fsqrt_s", fsqrt_s, 32'h4080_0000);
        nxt();
        req0_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("single_early_valid", 32'(resp_valid), 32'h0);
            nxt();
        end
        @(negedge clk);
        chk("single_valid", 32'(resp_valid), 32'h1);
        chk("single_data", resp_data, 32'h4000_0000);
        chk("single_src", 32'(resp_src), 32'h0);
        chk("single_tag", 32'(resp_tag), 32'h3);
        nxt();
        idle(3);

        // Negative operand from requester 1
        req1_valid = 1'b1; req1_data = 32'hC080_0000; req1_tag = 4'd9;
        nxt();
        req1_valid = 1'b0;
        wait_resp("neg_wait", got);
        if (got) begin
            chk("neg_data", resp_data, 32'h0);
            chk("neg_src", 32'(resp_src), 32'h1);
            chk("neg_tag", 32'(resp_tag), 32'h9);
            nxt();
        end
        idle(4);

        // Contention from reset: strict alternation, one response per cycle
        do_reset();
        t0 = '0; t1 = '0;
        req0_valid = 1'b1; req0_data = 32'h4110_0000; req0_tag = t0;
        req1_valid = 1'b1; req1_data = 32'h4000_0000; req1_tag = t1;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            chk("cont_gnt0", 32'(req0_ready), 32'((j % 2) == 0));
            chk("cont_gnt1", 32'(req1_ready), 32'((j % 2) == 1));
            a0 = req0_ready; a1 = req1_ready;
            if (j >= LAT + 1) begin
                chk("cont_resp_valid", 32'(resp_valid), 32'h1);
                chk("cont_resp_src", 32'(resp_src), 32'((j - LAT - 1) % 2));
                chk("cont_resp_data", resp_data, ((j - LAT - 1) % 2) == 0 ? 32'h4040_0000 : 32'h3FB5_04F3);
                chk("cont_resp_tag", 32'(resp_tag), 32'((j - LAT - 1) / 2));
            end
            nxt();
            if (a0) t0++;
            if (a1) t1++;
            req0_tag = t0; req1_tag = t1;
        end
        idle(12);

        // Backpressure: credits admit exactly DEPTH ops, then drain in order
        resp_ready = 1'b0;
        acc = 0;
        req0_valid = 1'b1; req0_data = 32'h4080_0000; req0_tag = '0;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            a0 = req0_ready;
            nxt();
            if (a0) acc++;
            req0_tag = TAG_W'(acc);
        end
        chk("bp_accepted", 32'(acc), 32'(DEPTH));
        @(negedge clk);
        chk("bp_stalled", 32'(req0_ready), 32'h0);
        nxt();
        req0_valid = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk("bp_drain_valid", 32'(resp_valid), 32'h1);
            chk("bp_drain_tag", 32'(resp_tag), 32'(i));
            nxt();
        end
        @(negedge clk);
        chk("bp_drained", 32'(resp_valid), 32'h0);
        nxt();

        // Reset with operations in flight
        req0_valid = 1'b1; req0_data = 32'h4110_0000; req0_tag = 4'd1;
        repeat (3) nxt();
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst_req0_ready", 32'(req0_ready), 32'h0);
        chk("midrst_fsqrt_s", fsqrt_s, 32'h0);
        chk("midrst_resp_valid", 32'(resp_valid), 32'h0);
        chk("midrst_resp_data", resp_data, 32'h0);
        nxt();
        req0_valid = 1'b0;
        nxt();
        rstn = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            chk("midrst_no_stale", 32'(resp_valid), 32'h0);
            nxt();
        end
        req0_valid = 1'b1; req0_data = 32'h3F80_0000; req0_tag = 4'd5;
        nxt();
        req0_valid = 1'b0;
        wait_resp("midrst_wait", got);
        if (got) begin
            chk("midrst_new_data", resp_data, 32'h3F80_0000);
            chk("midrst_new_tag", 32'(resp_tag), 32'h5);
            nxt();
        end
        idle(4);

        // Random traffic, first with heavy backpressure then light
        a0 = 1'b0; a1 = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (!req0_valid || a0) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_data  = $urandom;
                req0_tag   = TAG_W'($urandom);
            end
            if (!req1_valid || a1) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_data  = ($urandom_range(0, 7) == 0) ? 32'h4000_0000 : $urandom;
                req1_tag   = TAG_W'($urandom);
            end
            resp_ready = (k < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            @(negedge clk);
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            nxt();
        end
        resp_ready = 1'b1;
        idle(40);
        @(negedge clk);
        chk("final_empty", 32'(resp_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
